// File: rtl/secuenciador_glifos_pkg.sv
// Shared types and constants for the BCD glyph sequencer.
// State encoding, blank row value, invalid decoder base, default sizes.
package secuenciador_glifos_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ADDR,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0]  BLANK_ROW      = 8'h00;
  localparam logic [10:0] INVALID_BASE   = 11'h000;
  localparam int          DEF_NUM_BYTES  = 3;
  localparam int          DEF_GLYPH_ROWS = 16;
  localparam int          DEF_ROM_LAT    = 1;

endpackage

// File: rtl/secuenciador_glifos_if.sv
// Valid/ready write port toward the line/frame buffer.
// master: valid, addr, data out, ready in. slave: mirror.
interface secuenciador_glifos_if #(
  parameter int WA = 7
);
  logic          valid;
  logic          ready;
  logic [WA-1:0] addr;
  logic [7:0]    data;

  modport master (output valid, addr, data, input ready);
  modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/secuenciador_glifos_contador_digito_fila.sv
// Digit/row walk counters with last-row and last-digit flags.
// clr zeroes both; adv steps row, wrapping into the next digit.
module contador_digito_fila #(
  parameter int NDIG = 6,
  parameter int ROWS = 16,
  parameter int DW   = $clog2(NDIG),
  parameter int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [DW-1:0] digit_o,
  output logic [RW-1:0] row_o,
  output logic          last_row_o,
  output logic          last_digit_o
);

  logic [DW-1:0] digit_q, digit_d;
  logic [RW-1:0] row_q, row_d;

  assign last_row_o   = (row_q == RW'(ROWS - 1));
  assign last_digit_o = (digit_q == DW'(NDIG - 1));
  assign digit_o      = digit_q;
  assign row_o        = row_q;

  always_comb begin
    digit_d = digit_q;
    row_d   = row_q;
    if (clr) begin
      digit_d = '0;
      row_d   = '0;
    end else if (adv) begin
      if (last_row_o) begin
        row_d   = '0;
        digit_d = last_digit_o ? '0 : digit_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
      row_q   <= '0;
    end else begin
      digit_q <= digit_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/secuenciador_glifos.sv
// Walks latched packed-BCD bytes nibble by nibble, fetches glyph rows
// from the font ROM and pushes them to the buffer over wr (valid/ready).
// Ports: clk, reset (async, high), start, bcd_bus, dato_o/selector_o to
// the address decoder, direccion_i from it, rom_addr_o/rom_data_i to the
// font ROM, wr (master write port), busy_o, done_o, err_o (sticky).
module secuenciador_glifos
  import secuenciador_glifos_pkg::*;
#(
  parameter int NUM_BYTES  = DEF_NUM_BYTES,
  parameter int GLYPH_ROWS = DEF_GLYPH_ROWS,
  parameter int ROM_LAT    = DEF_ROM_LAT,
  parameter int WA         = $clog2(2 * NUM_BYTES * GLYPH_ROWS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] bcd_bus,
  output logic [7:0]             dato_o,
  output logic                   selector_o,
  input  logic [10:0]            direccion_i,
  output logic [10:0]            rom_addr_o,
  input  logic [7:0]             rom_data_i,
  secuenciador_glifos_if.master  wr,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int NDIG = 2 * NUM_BYTES;
  localparam int DW   = $clog2(NDIG);
  localparam int RW   = $clog2(GLYPH_ROWS);
  localparam int BB   = 8 * NUM_BYTES;
  localparam int LW   = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_t        state_q, state_d;
  logic [BB-1:0] bcd_q, bcd_d;
  logic [7:0]    dato_q, dato_d;
  logic          sel_q, sel_d;
  logic [10:0]   rom_addr_q, rom_addr_d;
  logic          blank_q, blank_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          wr_valid_q, wr_valid_d;
  logic [WA-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          cnt_clr, cnt_adv;
  logic [DW-1:0] digit;
  logic [RW-1:0] row;
  logic          last_row, last_digit;
  logic [BB-1:0] bcd_sh;
  logic [7:0]    byte_sel;

  contador_digito_fila #(
    .NDIG (NDIG),
    .ROWS (GLYPH_ROWS)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .clr          (cnt_clr),
    .adv          (cnt_adv),
    .digit_o      (digit),
    .row_o        (row),
    .last_row_o   (last_row),
    .last_digit_o (last_digit)
  );

  // Two digits per byte; most significant byte is shown first.
  assign bcd_sh   = bcd_q << (8 * int'(digit >> 1));
  assign byte_sel = bcd_sh[BB-1 -: 8];

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    dato_d     = dato_q;
    sel_d      = sel_q;
    rom_addr_d = rom_addr_q;
    blank_d    = blank_q;
    lat_d      = lat_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d   = bcd_bus;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        dato_d  = byte_sel;
        sel_d   = ~digit[0];
        state_d = S_ADDR;
      end
      S_ADDR: begin
        // Decoder returns 0 for a nibble above 9: emit blank rows.
        if (direccion_i == INVALID_BASE) begin
          err_d   = 1'b1;
          blank_d = 1'b1;
        end else begin
          blank_d    = 1'b0;
          rom_addr_d = direccion_i + 11'(row);
        end
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LW'(ROM_LAT - 1)) begin
          wr_data_d  = blank_q ? BLANK_ROW : rom_data_i;
          wr_addr_d  = WA'(digit) * WA'(GLYPH_ROWS) + WA'(row);
          wr_valid_d = 1'b1;
          state_d    = S_WRITE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (wr.ready) begin
          wr_valid_d = 1'b0;
          cnt_adv    = 1'b1;
          if (!last_row) begin
            state_d = S_ADDR;
          end else if (last_digit) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LATCH;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      dato_q     <= '0;
      sel_q      <= 1'b0;
      rom_addr_q <= '0;
      blank_q    <= 1'b0;
      lat_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      dato_q     <= dato_d;
      sel_q      <= sel_d;
      rom_addr_q <= rom_addr_d;
      blank_q    <= blank_d;
      lat_q      <= lat_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign dato_o     = dato_q;
  assign selector_o = sel_q;
  assign rom_addr_o = rom_addr_q;
  assign wr.valid   = wr_valid_q;
  assign wr.addr    = wr_addr_q;
  assign wr.data    = wr_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
